// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit saturating-counter direction predictor.
// Zero-latency lookup for fetch, registered training, saturating stats.
module branch_predictor #(
   parameter int PC_W   = 16,
   parameter int IDX_W  = 6,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lk_valid,
   input  logic [PC_W-1:0]   lk_pc,
   output logic              lk_taken,
   input  logic              upd_valid,
   input  logic [PC_W-1:0]   upd_pc,
   input  logic [2:0]        upd_cond,
   input  logic              upd_pred,
   input  logic              upd_miss,
   input  logic              tbl_clr,
   output logic [STAT_W-1:0] stat_br,
   output logic [STAT_W-1:0] stat_miss
);

   localparam int N = 1 << IDX_W;

   logic [1:0]        tbl_q [N];
   logic [STAT_W-1:0] br_q;
   logic [STAT_W-1:0] br_d;
   logic [STAT_W-1:0] miss_q;
   logic [STAT_W-1:0] miss_d;
   logic [IDX_W-1:0]  lk_idx;
   logic [IDX_W-1:0]  upd_idx;
   logic              upd_en;
   logic              act;
   logic [1:0]        cur;
   logic [1:0]        ctr_d;
   logic              unused_pc_hi;

   assign lk_idx   = lk_pc[IDX_W-1:0];
   assign upd_idx  = upd_pc[IDX_W-1:0];
   assign lk_taken = lk_valid & tbl_q[lk_idx][1];
   assign stat_br   = br_q;
   assign stat_miss = miss_q;

   // Upper PC bits do not take part in indexing (tagless table).
   assign unused_pc_hi = ^{lk_pc[PC_W-1:IDX_W],
                           upd_pc[PC_W-1:IDX_W]};

   // Next counter value and next statistics for the resolved branch.
   always_comb begin
      act    = upd_pred ^ upd_miss;
      upd_en = upd_valid & (upd_cond != 3'd7);
      cur    = tbl_q[upd_idx];
      ctr_d  = cur;
      br_d   = br_q;
      miss_d = miss_q;
      if (act) begin
         if (cur != 2'b11) ctr_d = cur + 2'b01;
      end else begin
         if (cur != 2'b00) ctr_d = cur - 2'b01;
      end
      if (upd_en) begin
         if (br_q != '1) br_d = br_q + 1'b1;
         if (upd_miss && (miss_q != '1))
            miss_d = miss_q + 1'b1;
      end
   end

   // Counter table: clear wins over training; single write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++)
            tbl_q[i] <= 2'b01;
      end else if (tbl_clr) begin
         for (int i = 0; i < N; i++)
            tbl_q[i] <= 2'b01;
      end else if (upd_en) begin
         tbl_q[upd_idx] <= ctr_d;
      end
   end

   // Statistics count every trained branch, even when the table clears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_q   <= '0;
         miss_q <= '0;
      end else begin
         br_q   <= br_d;
         miss_q <= miss_d;
      end
   end

endmodule
